// File: rtl/mux_pkg.sv
// Shared defaults for the registered 2:1 mux.
package mux_pkg;
  localparam int   MUX_WIDTH_DEF   = 1;
  localparam logic MUX_RST_BIT_DEF = 1'b0;
endpackage

// File: rtl/mux_sel_det.sv
// Select-change detector: pulses when the accepted select differs from the
// previously accepted one. The first sample after reset never pulses.
module mux_sel_det
  import mux_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic c,
  output logic sel_chg
);

  logic sel;
  logic prev_sel;
  logic seen;

  // An unknown select resolves to 0, matching the data path.
  always_comb begin
    sel = 1'b0;
    if (c == 1'b1) sel = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_sel <= 1'b0;
      seen     <= 1'b0;
      sel_chg  <= 1'b0;
    end else if (in_valid) begin
      sel_chg  <= seen && (sel != prev_sel);
      prev_sel <= sel;
      seen     <= 1'b1;
    end else begin
      sel_chg  <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_2to1.sv
// Registered 2:1 mux with valid tracking; the select-change detector is
// compiled in only when MUX_SEL_CHG_EN is defined.
module mux_2to1
  import mux_pkg::*;
#(
  parameter int               WIDTH   = MUX_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{MUX_RST_BIT_DEF}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic             sel_chg
);

  // An if on c takes the else branch for X/Z, so unknown selects pick a.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= RST_VAL;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        if (c == 1'b1) y <= b;
        else           y <= a;
      end
    end
  end

`ifdef MUX_SEL_CHG_EN
  mux_sel_det u_sel_det (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .c        (c),
    .sel_chg  (sel_chg)
  );
`else
  assign sel_chg = 1'b0;
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench: a 1-bit and an 8-bit instance driven in lockstep and
// compared against a transaction-level model of the mux rules.
module tb_mux_2to1;

  localparam logic [7:0] RST8 = 8'hA5;
  // y for index {a,b,c}, listed from index 7 down to 0
  localparam logic [7:0] TRUTH = 8'b1101_1000;
`ifdef MUX_SEL_CHG_EN
  localparam logic SC_EN = 1'b1;
`else
  localparam logic SC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       c = 1'b0;
  logic       in_valid = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       y1, ov1, sc1;
  logic [7:0] y8;
  logic       ov8, sc8;

  int checks = 0;
  int errors = 0;

  // model state
  logic       exp_y1 = 1'b0;
  logic [7:0] exp_y8 = RST8;
  logic       exp_ov = 1'b0;
  logic       exp_sc = 1'b0;
  logic       prev_c = 1'b0;
  logic       have_prev = 1'b0;

  always #5 clk = ~clk;

  mux_2to1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c), .in_valid(in_valid),
    .y(y1), .out_valid(ov1), .sel_chg(sc1)
  );

  mux_2to1 #(.WIDTH(8), .RST_VAL(RST8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c), .in_valid(in_valid),
    .y(y8), .out_valid(ov8), .sel_chg(sc8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".y1"}, 32'(y1), 32'(exp_y1));
    check({tag, ".y8"}, 32'(y8), 32'(exp_y8));
    check({tag, ".ov1"}, 32'(ov1), 32'(exp_ov));
    check({tag, ".ov8"}, 32'(ov8), 32'(exp_ov));
    check({tag, ".sc1"}, 32'(sc1), 32'(exp_sc));
    check({tag, ".sc8"}, 32'(sc8), 32'(exp_sc));
  endtask

  // Called at a falling edge: drive one cycle, check 1 time unit after the rising edge.
  task automatic cycle(input string tag, input logic iv, input logic av, input logic bv,
                       input logic [7:0] a8v, input logic [7:0] b8v, input logic cv);
    logic chg;
    in_valid = iv; a1 = av; b1 = bv; a8 = a8v; b8 = b8v; c = cv;
    @(posedge clk);
    #1;
    chg = iv && have_prev && (cv != prev_c);
    if (iv) begin
      exp_y1 = cv ? bv : av;
      exp_y8 = cv ? b8v : a8v;
      prev_c = cv;
      have_prev = 1'b1;
    end
    exp_ov = iv;
    exp_sc = chg & SC_EN;
    $display("txn %s iv=%0b a=%0b b=%0b a8=%02h b8=%02h c=%0b -> y1=%0b y8=%02h ov=%0b sc=%0b",
             tag, iv, av, bv, a8v, b8v, cv, y1, y8, ov1, sc1);
    check_all(tag);
    @(negedge clk);
  endtask

  // Called at a falling edge: assert reset mid-cycle, check immediately, release on next falling edge.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    exp_y1 = 1'b0; exp_y8 = RST8; exp_ov = 1'b0; exp_sc = 1'b0; have_prev = 1'b0;
    $display("txn %s reset asserted mid-cycle", tag);
    check_all(tag);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] idx;
    @(negedge clk);
    $display("txn power-on reset");
    check_all("por");
    rst_n = 1'b1;

    // accept something non-reset, then reset mid-cycle
    cycle("pre", 1'b1, 1'b1, 1'b0, 8'h11, 8'h22, 1'b0);
    do_reset("rst_mid");

    // full truth table
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      cycle("tt", 1'b1, idx[2], idx[1], 8'($urandom), 8'($urandom), idx[0]);
      check("tt.table", 32'(y1), 32'(TRUTH[idx]));
    end

    // hold on idle cycle
    cycle("hold_load", 1'b1, 1'b1, 1'b0, 8'h0F, 8'hF0, 1'b0);
    cycle("hold_idle", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    check("hold.y1_is_1", 32'(y1), 32'd1);

    // select-change sequence after a fresh reset
    do_reset("rst_sc");
    cycle("sc0", 1'b1, 1'b0, 1'b1, 8'h01, 8'h02, 1'b0);
    check("sc.first_no_pulse", 32'(sc1), 32'd0);
    cycle("sc1", 1'b1, 1'b0, 1'b1, 8'h01, 8'h02, 1'b0);
    cycle("sc2", 1'b1, 1'b0, 1'b1, 8'h01, 8'h02, 1'b1);
    check("sc.change_pulse", 32'(sc1), 32'(SC_EN));
    cycle("sc3", 1'b1, 1'b0, 1'b1, 8'h01, 8'h02, 1'b1);
    // idle gap must not forget the previous select
    cycle("sc_idle", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cycle("sc4", 1'b1, 1'b0, 1'b1, 8'h01, 8'h02, 1'b0);

    // wide data
    cycle("wide_b", 1'b1, 1'b0, 1'b0, 8'h5A, 8'hC3, 1'b1);
    check("wide.c3", 32'(y8), 32'hC3);
    cycle("wide_a", 1'b1, 1'b0, 1'b0, 8'h5A, 8'hC3, 1'b0);
    check("wide.5a", 32'(y8), 32'h5A);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      cycle("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 1'($urandom));
    end

    // reset while an input is pending: nothing may emerge after release
    in_valid = 1'b1; a1 = 1'b1; b1 = 1'b1; a8 = 8'h77; b8 = 8'h88; c = 1'b1;
    do_reset("rst_pending");
    cycle("post_rst", 1'b0, 1'b1, 1'b1, 8'h77, 8'h88, 1'b1);
    check("post_rst.no_ov", 32'(ov1), 32'd0);
    cycle("post_rst_first", 1'b1, 1'b0, 1'b1, 8'h33, 8'h44, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux_2to1.md
MUX_2TO1 -- requirements
Module: mux_2to1

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 1, which sets the data width of a, b and y.
REQ-002 The block SHALL provide parameter RST_VAL, default all-zeros, which sets the value y takes under reset.
REQ-003 The block SHALL run from one clock, clk (input, 1 bit), sampled on its rising edge.
REQ-004 The block SHALL take reset rst_n (input, 1 bit), which is asynchronous and active-low.
REQ-005 The block SHALL take a (input, WIDTH bits), the data selected when c=0.
REQ-006 The block SHALL take b (input, WIDTH bits), the data selected when c=1.
REQ-007 The block SHALL take c (input, 1 bit), the select.
REQ-008 The block SHALL take in_valid (input, 1 bit), which marks a, b and c as valid this cycle.
REQ-009 The block SHALL drive y (output, WIDTH bits), the registered mux result.
REQ-010 The block SHALL drive out_valid (output, 1 bit), which marks y as updated this cycle.
REQ-011 The block SHALL drive sel_chg (output, 1 bit), a one-cycle pulse indicating that the accepted select differs from the previously accepted select.

Function
REQ-012 On each rising clk edge with in_valid=1, the block SHALL load y with b when c=1 and with a when c=0, bitwise across WIDTH.
REQ-013 Full 3-input truth table for WIDTH=1, listed as (a,b,c)->y: 000->0, 001->0, 010->0, 011->1, 100->1, 101->0, 110->1, 111->1.
REQ-014 Latency SHALL be exactly one cycle from an accepted input to y and out_valid.
REQ-015 A cycle with in_valid=0 SHALL leave y holding its last value and SHALL drive out_valid to 0 in the next cycle.
REQ-016 out_valid SHALL equal in_valid delayed by one cycle; there is no backpressure.
REQ-017 sel_chg SHALL assert in the same cycle as out_valid when the accepted c differs from the last accepted c.
REQ-018 sel_chg SHALL NOT assert on the first accepted sample after reset.
REQ-019 Idle cycles (in_valid=0) between accepted samples SHALL NOT clear the stored previous select.
REQ-020 When c is X or Z on an accepted cycle, the block SHALL load y with a and SHALL treat the select as 0; simulation only.

Reset
REQ-021 While rst_n=0, the block SHALL force y=RST_VAL, out_valid=0 and sel_chg=0, and SHALL clear the stored previous select and the first-sample flag, all immediately and without waiting for clk.
REQ-022 Reset deassertion SHALL be synchronized by the integrator; the block SHALL accept input on the first rising edge at which rst_n=1.
REQ-023 Reset asserted mid-stream SHALL discard any pending result; no out_valid pulse SHALL follow reset release without a new accepted input.

Configuration
REQ-024 When macro MUX_SEL_CHG_EN is defined, the select-change detector SHALL be compiled in and SHALL behave per REQ-017 to REQ-019.
REQ-025 When MUX_SEL_CHG_EN is undefined, sel_chg SHALL be tied to constant 0 and no previous-select state SHALL be synthesized; the port SHALL remain present.

Structure
REQ-026 Package mux_pkg SHALL hold the WIDTH default constant and the RST_VAL default constant.
REQ-027 The select-change detector SHALL be a sub-module, mux_sel_det, instantiated only under MUX_SEL_CHG_EN.
REQ-028 The data path SHALL be a single register stage with no latches; all flops SHALL be reset by rst_n.

Verification
REQ-029 Reset: assert rst_n=0 mid-cycle with WIDTH=1 and RST_VAL=0 -> y=0, out_valid=0 and sel_chg=0 immediately, before any clk edge.
REQ-030 Truth table: drive all 8 (a,b,c) combinations with in_valid=1, one per cycle -> y matches REQ-013 one cycle later and out_valid=1 on each cycle.
REQ-031 Hold: accept a=1, b=0, c=0 (y=1), then apply in_valid=0 with a=0 -> y stays 1 and out_valid=0.
REQ-032 Select change: accept c=0, then c=0, then c=1, then c=1 -> sel_chg sequence 0,0,1,0, with no pulse on the first sample.
REQ-033 Wide data: WIDTH=8, a=8'h5A, b=8'hC3; accept c=1, then c=0 -> y=8'hC3, then y=8'h5A.
REQ-034 Configuration: build without MUX_SEL_CHG_EN and rerun REQ-032 -> sel_chg stays 0 throughout.
